// File: rtl/multicycle_main_control_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM.
// This file holds the opcode and funct constants, the datapath select encodings,
// the state encoding and the control-vector type.
package multicycle_main_control_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // Funct codes (IR[5:0]) understood by the ALU-control decoder
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_ACCM = 6'b111000;

    // Commands sent to the ALU-control decoder
    localparam logic [2:0] ALUOp_CMD_ADD   = 3'd0;
    localparam logic [2:0] ALUOp_CMD_SUB   = 3'd1;
    localparam logic [2:0] ALUOp_CMD_RTYPE = 3'd2;

    // ALU operand B select
    localparam logic [1:0] ALUSrcB_REG     = 2'b00;
    localparam logic [1:0] ALUSrcB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSrcB_IMM     = 2'b10;
    localparam logic [1:0] ALUSrcB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSource_ALU    = 2'b00;
    localparam logic [1:0] PCSource_ALUOUT = 2'b01;
    localparam logic [1:0] PCSource_JUMP   = 2'b10;

    // FSM state encoding, also visible on the debug state port
    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_IF       = 4'd1,
        S_ID       = 4'd2,
        S_ACCM_RD  = 4'd3,
        S_EX_R     = 4'd4,
        S_WB_R     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_M     = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BR       = 4'd10,
        S_JMP      = 4'd11,
        S_EX_I     = 4'd12,
        S_WB_I     = 4'd13
    } state_t;

    // Every datapath enable and select driven by the FSM
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] aluop;
    } ctrl_t;

    // All enables off, every select 0, aluop = ADD
    localparam ctrl_t CTRL_IDLE = '0;

    // True for the R-type funct codes the ALU-control decoder implements
    function automatic logic funct_defined(input logic [5:0] f);
        case (f)
            FUNCT_SLL, FUNCT_SRL, FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
            FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR, FUNCT_SLT, FUNCT_ACCM:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_main_control_if.sv
// Bundle between the main control FSM and the multi-cycle datapath.
// The datapath side (master) supplies the instruction fields and the run gate.
// The control side (slave) returns the enables, selects and status.
interface multicycle_main_control_if #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 32
);
    logic                run;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    logic                zero;

    logic                pc_write;
    logic                pc_write_cond;
    logic [1:0]          pc_source;
    logic                i_or_d;
    logic                mem_read;
    logic                mem_write;
    logic                ir_write;
    logic                mem_to_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUOP_W-1:0]  aluop;
    logic                illegal;
    logic [3:0]          state;
    logic [CNT_W-1:0]    instr_cnt;

    modport master (
        output run, opcode, funct, zero,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               aluop, illegal, state, instr_cnt
    );

    modport slave (
        input  run, opcode, funct, zero,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
               aluop, illegal, state, instr_cnt
    );
endinterface

// File: rtl/mcc_output_decode.sv
// Moore output decoder: maps the current FSM state to the full control vector.
// It is purely combinational. The run gate is applied by the top level.
module mcc_output_decode
    import multicycle_main_control_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    // Per-state enables and selects; unlisted fields keep the idle value
    always_comb begin
        // NOTE: the default assignment first covers every path, so no latch is inferred.
        ctrl = CTRL_IDLE;
        case (state)
            S_IF: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUSrcB_FOUR;
                ctrl.aluop     = ALUOp_CMD_ADD;
                ctrl.pc_source = PCSource_ALU;
            end
            S_ID: begin
                // Branch target is precomputed into ALUOut
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = ALUSrcB_IMM_SH2;
                ctrl.aluop     = ALUOp_CMD_ADD;
            end
            S_ACCM_RD: begin
                // RTYPE makes the ALU decoder address memory from Rs
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                ctrl.aluop    = ALUOp_CMD_RTYPE;
            end
            S_EX_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSrcB_REG;
                ctrl.aluop     = ALUOp_CMD_RTYPE;
            end
            S_WB_R: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSrcB_IMM;
                ctrl.aluop     = ALUOp_CMD_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_WB_M: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_BR: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUSrcB_REG;
                ctrl.aluop         = ALUOp_CMD_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSource_ALUOUT;
            end
            S_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSource_JUMP;
            end
            S_EX_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSrcB_IMM;
                ctrl.aluop     = ALUOp_CMD_ADD;
            end
            S_WB_I: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// It sequences fetch, decode, execute, memory and writeback, counts retired
// instructions and flags undefined opcode/funct codes. Outputs are Moore-decoded
// from the state register; run=0 freezes the FSM and masks every write enable.
module multicycle_main_control
    import multicycle_main_control_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multicycle_main_control_if.slave   bus
);

    state_t              state_q;
    logic                illegal_q;
    logic [CNT_W-1:0]    instr_cnt_q;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT_W-1:0]  funct;
    ctrl_t               ctrl_dec;
    ctrl_t               ctrl_out;

    assign opcode = bus.opcode;
    assign funct  = bus.funct;

    // The zero flag is consumed by the datapath through pc_write_cond
    logic unused_zero;
    assign unused_zero = bus.zero;

    // State sequencing, sticky illegal flag and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            illegal_q   <= 1'b0;
            instr_cnt_q <= '0;
        end else if (bus.run) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values, matching real hardware.
            case (state_q)
                S_INIT: state_q <= S_IF;
                S_IF:   state_q <= S_ID;
                S_ID: begin
                    case (opcode)
                        OP_RTYPE: begin
                            state_q <= (funct == FUNCT_ACCM) ? S_ACCM_RD : S_EX_R;
                            if (!funct_defined(funct)) illegal_q <= 1'b1;
                        end
                        OP_LW, OP_SW: state_q <= S_MEM_ADDR;
                        OP_BEQ:       state_q <= S_BR;
                        OP_J:         state_q <= S_JMP;
                        OP_ADDI:      state_q <= S_EX_I;
                        default: begin
                            illegal_q <= 1'b1;
                            state_q   <= S_IF;
                        end
                    endcase
                end
                S_ACCM_RD:  state_q <= S_EX_R;
                S_EX_R:     state_q <= S_WB_R;
                S_MEM_ADDR: state_q <= (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   state_q <= S_WB_M;
                S_EX_I:     state_q <= S_WB_I;
                S_WB_R, S_WB_M, S_MEM_WR, S_BR, S_JMP, S_WB_I: begin
                    state_q     <= S_IF;
                    instr_cnt_q <= instr_cnt_q + CNT_W'(1);
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

    mcc_output_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl_dec)
    );

    // Freeze all architectural writes while run is low
    always_comb begin
        ctrl_out = ctrl_dec;
        if (!bus.run) begin
            ctrl_out.pc_write      = 1'b0;
            ctrl_out.pc_write_cond = 1'b0;
            ctrl_out.mem_write     = 1'b0;
            ctrl_out.ir_write      = 1'b0;
            ctrl_out.reg_write     = 1'b0;
        end
    end

    assign bus.pc_write      = ctrl_out.pc_write;
    assign bus.pc_write_cond = ctrl_out.pc_write_cond;
    assign bus.pc_source     = ctrl_out.pc_source;
    assign bus.i_or_d        = ctrl_out.i_or_d;
    assign bus.mem_read      = ctrl_out.mem_read;
    assign bus.mem_write     = ctrl_out.mem_write;
    assign bus.ir_write      = ctrl_out.ir_write;
    assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
    assign bus.reg_dst       = ctrl_out.reg_dst;
    assign bus.reg_write     = ctrl_out.reg_write;
    assign bus.alu_src_a     = ctrl_out.alu_src_a;
    assign bus.alu_src_b     = ctrl_out.alu_src_b;
    assign bus.aluop         = ALUOP_W'(ctrl_out.aluop);
    assign bus.illegal       = illegal_q;
    assign bus.state         = state_q;
    assign bus.instr_cnt     = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control.
// An instruction-level model predicts the state walk of each instruction class,
// the per-state control values, the retire count and the illegal flag.
// One compare process checks every cycle; directed literal checks pin the model.
module tb_multicycle_main_control;
    import multicycle_main_control_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_main_control_if bus ();

    multicycle_main_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] aluop;
    } tb_ctl_t;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [5:0] legal_fn [12] = '{6'b000000, 6'b000010, 6'b100000, 6'b100001,
                                  6'b100010, 6'b100011, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b101010, 6'b111000};
    state_t      m_plan [$];
    int          m_idx     = 0;
    bit          m_init    = 1'b1;
    bit          m_retire  = 1'b0;
    bit          m_flag_il = 1'b0;
    bit          m_illegal = 1'b0;
    logic [31:0] m_cnt     = '0;
    bit          rand_mode = 1'b0;

    function automatic bit is_legal_fn(input logic [5:0] f);
        foreach (legal_fn[i]) if (legal_fn[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    // Whole state walk of one instruction, from its fetch to its last cycle
    function automatic void build_plan(input logic [5:0] op, input logic [5:0] fn);
        m_plan = {S_IF, S_ID};
        m_retire = 1'b1;
        m_flag_il = 1'b0;
        case (op)
            6'b000000: begin
                if (fn == 6'b111000) m_plan.push_back(S_ACCM_RD);
                m_plan.push_back(S_EX_R);
                m_plan.push_back(S_WB_R);
                m_flag_il = !is_legal_fn(fn);
            end
            6'b100011: begin m_plan.push_back(S_MEM_ADDR); m_plan.push_back(S_MEM_RD); m_plan.push_back(S_WB_M); end
            6'b101011: begin m_plan.push_back(S_MEM_ADDR); m_plan.push_back(S_MEM_WR); end
            6'b000100: m_plan.push_back(S_BR);
            6'b000010: m_plan.push_back(S_JMP);
            6'b001000: begin m_plan.push_back(S_EX_I); m_plan.push_back(S_WB_I); end
            default: begin m_retire = 1'b0; m_flag_il = 1'b1; end
        endcase
        m_idx = 0;
    endfunction

    function automatic state_t exp_state();
        return m_init ? S_INIT : m_plan[m_idx];
    endfunction

    // Control values each state must show, straight from the state table
    function automatic tb_ctl_t exp_ctl(input state_t s, input logic r);
        tb_ctl_t c;
        c = '0;
        case (s)
            S_IF:       begin c.mem_read = 1; c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01; end
            S_ID:       c.alu_src_b = 2'b11;
            S_ACCM_RD:  begin c.mem_read = 1; c.i_or_d = 1; c.aluop = 3'd2; end
            S_EX_R:     begin c.alu_src_a = 1; c.aluop = 3'd2; end
            S_WB_R:     begin c.reg_dst = 1; c.reg_write = 1; end
            S_MEM_ADDR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_MEM_RD:   begin c.mem_read = 1; c.i_or_d = 1; end
            S_WB_M:     begin c.reg_write = 1; c.mem_to_reg = 1; end
            S_MEM_WR:   begin c.mem_write = 1; c.i_or_d = 1; end
            S_BR:       begin c.alu_src_a = 1; c.aluop = 3'd1; c.pc_write_cond = 1; c.pc_source = 2'b01; end
            S_JMP:      begin c.pc_write = 1; c.pc_source = 2'b10; end
            S_EX_I:     begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
            S_WB_I:     c.reg_write = 1;
            default:    c = '0;
        endcase
        if (!r) begin
            c.pc_write = 0; c.pc_write_cond = 0; c.mem_write = 0; c.ir_write = 0; c.reg_write = 0;
        end
        return c;
    endfunction

    function automatic tb_ctl_t dut_ctl();
        tb_ctl_t c;
        c = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
             bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write,
             bus.alu_src_a, bus.alu_src_b, bus.aluop};
        return c;
    endfunction

    task automatic start_instr();
        if (rand_mode) begin
            case ($urandom_range(0, 7))
                0, 1: bus.opcode = 6'b000000;
                2: bus.opcode = 6'b100011;
                3: bus.opcode = 6'b101011;
                4: bus.opcode = 6'b000100;
                5: bus.opcode = 6'b000010;
                6: bus.opcode = 6'b001000;
                default: bus.opcode = 6'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: bus.funct = legal_fn[$urandom_range(0, 11)];
                1: bus.funct = 6'b111000;
                2: bus.funct = 6'b100000;
                default: bus.funct = 6'($urandom);
            endcase
        end
        build_plan(bus.opcode, bus.funct);
    endtask

    task automatic advance(input logic r);
        if (!r) return;
        if (m_init) begin
            m_init = 1'b0;
            start_instr();
            return;
        end
        if (m_idx == 1 && m_flag_il) m_illegal = 1'b1;
        if (m_idx == m_plan.size() - 1) begin
            if (m_retire) m_cnt = m_cnt + 1;
            start_instr();
        end else begin
            m_idx++;
        end
    endtask

    task automatic model_reset();
        m_init = 1'b1;
        m_cnt = '0;
        m_illegal = 1'b0;
    endtask

    // One clock: run is applied before the edge, model follows just after it
    task automatic step(input logic r);
        bus.run = r;
        @(posedge clk);
        #2;
        advance(r);
        if (rand_mode) bus.zero = 1'($urandom);
    endtask

    // Override the instruction just fetched (model must be in IF)
    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        bus.opcode = op;
        bus.funct = fn;
        build_plan(op, fn);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("state", 64'(bus.state), 64'(exp_state()));
            check("ctrl", 64'(dut_ctl()), 64'(exp_ctl(exp_state(), bus.run)));
            check("illegal", 64'(bus.illegal), 64'(m_illegal));
            check("instr_cnt", 64'(bus.instr_cnt), 64'(m_cnt));
        end
    end

    // ---------------- directed helpers ----------------
    int lat, n_mw, n_rw, n_mtr, n_pwc, n_jmp, n_acc;

    // Run one instruction from its IF until the next IF, tallying key strobes
    task automatic do_instr(input logic [5:0] op, input logic [5:0] fn);
        set_instr(op, fn);
        lat = 0; n_mw = 0; n_rw = 0; n_mtr = 0; n_pwc = 0; n_jmp = 0; n_acc = 0;
        while (lat < 12) begin
            step(1'b1);
            lat++;
            if (bus.state == 4'd1) break;
            n_mw  += int'(bus.mem_write);
            n_rw  += int'(bus.reg_write);
            n_mtr += int'(bus.mem_to_reg && bus.reg_write);
            n_pwc += int'(bus.pc_write_cond && bus.aluop == 3'd1);
            n_jmp += int'(bus.pc_write && bus.pc_source == 2'b10);
            n_acc += int'(bus.state == 4'd3 && bus.mem_read && bus.i_or_d && bus.aluop == 3'd2);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.run = 1'b0;
        bus.opcode = 6'b000000;
        bus.funct = 6'b100000;
        bus.zero = 1'b0;
        #12 rst_n = 1'b1;

        check("reset_state", 64'(bus.state), 64'd0);
        check("reset_cnt", 64'(bus.instr_cnt), 64'd0);
        check("reset_illegal", 64'(bus.illegal), 64'd0);
        step(1'b0);
        step(1'b0);
        check("init_hold", 64'(bus.state), 64'd0);

        // ADD, traced cycle by cycle
        step(1'b1);
        check("add_if_state", 64'(bus.state), 64'd1);
        check("add_if_irw", 64'({bus.ir_write, bus.pc_write, bus.mem_read}), 64'b111);
        step(1'b1);
        check("add_id", 64'({bus.state, bus.alu_src_b}), {58'd0, 4'd2, 2'b11});
        step(1'b1);
        check("add_ex", 64'({bus.state, bus.aluop, bus.reg_write}), {56'd0, 4'd4, 3'd2, 1'b0});
        step(1'b1);
        check("add_wb", 64'({bus.state, bus.reg_write, bus.reg_dst}), {58'd0, 4'd5, 2'b11});
        step(1'b1);
        check("add_retire", 64'(bus.instr_cnt), 64'd1);

        do_instr(6'b000000, 6'b111000);
        check("accm_lat", 64'(lat), 64'd5);
        check("accm_rd", 64'(n_acc), 64'd1);
        do_instr(6'b100011, 6'b000000);
        check("lw_lat", 64'(lat), 64'd5);
        check("lw_mtr", 64'(n_mtr), 64'd1);
        do_instr(6'b101011, 6'b000000);
        check("sw_lat", 64'(lat), 64'd4);
        check("sw_wr", 64'({n_mw[7:0], n_rw[7:0]}), 64'h0100);
        do_instr(6'b000100, 6'b000000);
        check("beq_lat", 64'(lat), 64'd3);
        check("beq_pwc", 64'(n_pwc), 64'd1);
        do_instr(6'b000010, 6'b000000);
        check("j_lat", 64'(lat), 64'd3);
        check("j_pw", 64'(n_jmp), 64'd1);
        do_instr(6'b001000, 6'b000000);
        check("addi_lat", 64'(lat), 64'd4);
        check("addi_rw", 64'(n_rw), 64'd1);
        check("cnt_after7", 64'(bus.instr_cnt), 64'd7);

        // Undefined opcode
        check("pre_illegal", 64'(bus.illegal), 64'd0);
        do_instr(6'b111111, 6'b000000);
        check("ill_lat", 64'(lat), 64'd2);
        check("ill_flag", 64'(bus.illegal), 64'd1);
        check("ill_cnt", 64'(bus.instr_cnt), 64'd7);

        // ADDI frozen for 3 cycles in EX_I
        set_instr(6'b001000, 6'b000000);
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check("hold_state", 64'(bus.state), 64'd12);
            check("hold_rw", 64'(bus.reg_write), 64'd0);
        end
        step(1'b1);
        check("wbi_rw", 64'(bus.reg_write), 64'd1);
        step(1'b1);
        check("hold_cnt", 64'(bus.instr_cnt), 64'd8);
        check("ill_sticky", 64'(bus.illegal), 64'd1);

        // R-type with an undefined funct still retires
        do_instr(6'b000000, 6'b111111);
        check("badfn_lat", 64'(lat), 64'd4);
        check("badfn_cnt", 64'(bus.instr_cnt), 64'd9);

        // Asynchronous reset in the middle of WB_R
        set_instr(6'b000000, 6'b100000);
        step(1'b1);
        step(1'b1);
        step(1'b1);
        check("pre_rst_wb", 64'({bus.state, bus.reg_write}), {59'd0, 4'd5, 1'b1});
        #1 rst_n = 1'b0;
        #1;
        check("rst_state", 64'(bus.state), 64'd0);
        check("rst_rw", 64'(bus.reg_write), 64'd0);
        check("rst_cnt", 64'(bus.instr_cnt), 64'd0);
        check("rst_ill", 64'(bus.illegal), 64'd0);
        model_reset();
        rst_n = 1'b1;
        step(1'b1);
        check("rst_if", 64'({bus.state, bus.ir_write}), {59'd0, 4'd1, 1'b1});

        // Randomized instruction stream with random run stalls
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 4) != 0));
            if (i == 1500) begin
                #1 rst_n = 1'b0;
                #1 model_reset();
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
